// File: rtl/shift_pkg.sv
// Shared shift definitions: datapath width, shift-amount width and right-shift FSM states.
package shift_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned SHAMT_W = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } srx_state_e;

endpackage

// File: rtl/srx_step.sv
// One combinational right-shift step of up to STEP positions with a selectable fill bit.
module srx_step #(
  parameter int unsigned N   = 32,
  parameter int unsigned K_W = 3
) (
  input  logic [N-1:0]   value,
  input  logic [K_W-1:0] k,
  input  logic           fill,
  output logic [N-1:0]   shifted_c
);

  // Extending with N copies of fill lets a plain logical shift bring fill into the vacated MSBs.
  logic [2*N-1:0] ext;

  assign ext       = {{N{fill}}, value} >> k;
  assign shifted_c = ext[N-1:0];

endmodule

// File: rtl/srx_iter_unit.sv
// Multi-cycle SRL/SRA unit: accepts one operand pair, shifts up to STEP bits per cycle, returns the result.
module srx_iter_unit
  import shift_pkg::*;
#(
  parameter int unsigned N    = XLEN,
  parameter int unsigned STEP = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_flush,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_arith,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_result
);

  localparam int unsigned SH_W = $clog2(N);
  localparam int unsigned K_W  = $clog2(STEP) + 1;

  srx_state_e      state_q, state_d;
  logic [N-1:0]    shreg_q, shreg_d;
  logic [SH_W-1:0] count_q, count_d;
  logic            fill_q, fill_d;
  logic            ready_q, valid_q;

  logic [SH_W-1:0] shamt_c;
  logic [K_W-1:0]  k_c;
  logic [N-1:0]    step_c;
  logic            unused_b_hi;

  // Only the low SH_W bits of the amount matter; upper bits are intentionally dropped.
  assign shamt_c     = i_b[SH_W-1:0];
  assign unused_b_hi = ^i_b[N-1:SH_W];

  assign k_c = (count_q >= SH_W'(STEP)) ? K_W'(STEP) : K_W'(count_q);

  srx_step #(
    .N   (N),
    .K_W (K_W)
  ) u_step (
    .value     (shreg_q),
    .k         (k_c),
    .fill      (fill_q),
    .shifted_c (step_c)
  );

  // Next-state and datapath update; flush overrides everything, including capture.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    count_d = count_q;
    fill_d  = fill_q;
    if (i_flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (i_valid) begin
            shreg_d = i_a;
            count_d = shamt_c;
            fill_d  = i_arith & i_a[N-1];
            state_d = (shamt_c == '0) ? S_DONE : S_BUSY;
          end
        end
        S_BUSY: begin
          shreg_d = step_c;
          count_d = count_q - SH_W'(k_c);
          if (count_d == '0) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (i_ready) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      count_q <= '0;
      fill_q  <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      count_q <= count_d;
      fill_q  <= fill_d;
      ready_q <= (state_d == S_IDLE);
      valid_q <= (state_d == S_DONE);
    end
  end

  assign o_ready  = ready_q;
  assign o_valid  = valid_q;
  assign o_result = shreg_q;

endmodule
